// File: rtl/shift_port_arbiter_pkg.sv
// Shared definitions for the shift-port arbiter: FSM encoding, port indices,
// default widths and a small port-to-one-hot helper.
package shift_port_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_AMT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_PWM = 1'b1;

    // One-hot per-port vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_PWM) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_port_arbiter_if.sv
// Request/response bundle between the two shift requesters and the arbiter.
interface shift_port_arbiter_if
    import shift_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_data0;
    logic [AMT_W-1:0]  req_amt0;
    logic [DATA_W-1:0] req_data1;
    logic [AMT_W-1:0]  req_amt1;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_data;

    // Requester side (ALU and PWM paths).
    modport master (
        output req_valid, req_data0, req_amt0, req_data1, req_amt1, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data0, req_amt0, req_data1, req_amt1, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/shift_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant from the valid pair and the
// preferred port used only to break a tie.
module rr_pick2 (
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    // Lone requester always wins; on a tie the preferred port wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/shift_port_arbiter.sv
// Shares one external combinational arithmetic right shifter between the ALU
// SRA port (0) and the PWM scaling port (1). Operands are registered toward
// the shifter, the result is captured one cycle later and held until the
// owning port accepts it.
module shift_port_arbiter
    import shift_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AMT_W  = DEF_AMT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    shift_port_arbiter_if.slave  bus,
    output logic [DATA_W-1:0]    sh_operand,
    output logic [AMT_W-1:0]     sh_amt,
    input  logic [DATA_W-1:0]    sh_result,
    output logic                 busy
);

    state_t            state_r;
    state_t            next_s;
    logic              owner_r;
    logic              rr_ptr_r;
    logic [DATA_W-1:0] sh_operand_r;
    logic [AMT_W-1:0]  sh_amt_r;
    logic [DATA_W-1:0] resp_data_r;
    logic [1:0]        resp_valid_r;
    logic              busy_r;
    logic [1:0]        grant_s;
    logic [1:0]        req_ready_s;
    logic              accept_s;
    logic              handoff_s;

    rr_pick2 u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s)
    );

    // Grant is offered only in IDLE and never while reset is held.
    always_comb begin
        req_ready_s = 2'b00;
        if (state_r == IDLE && !reset) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    assign accept_s  = |(bus.req_valid & req_ready_s);
    assign handoff_s = (state_r == RESP) && bus.resp_ready[owner_r];

    // Next-state selection; the unused encoding falls back to IDLE.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_s = SHIFT;
                else          next_s = IDLE;
            end
            SHIFT: next_s = RESP;
            RESP: begin
                if (handoff_s) next_s = IDLE;
                else           next_s = RESP;
            end
            default: next_s = IDLE;
        endcase
    end

    // State, busy flag and response-valid registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            resp_valid_r <= 2'b00;
        end else begin
            state_r      <= next_s;
            busy_r       <= (next_s != IDLE);
            resp_valid_r <= (next_s == RESP) ? port_onehot(owner_r) : 2'b00;
        end
    end

    // Operand/amount/owner capture on acceptance; held until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_operand_r <= {DATA_W{1'b0}};
            sh_amt_r     <= {AMT_W{1'b0}};
            owner_r      <= PORT_ALU;
        end else if (state_r == IDLE && accept_s) begin
            sh_operand_r <= grant_s[1] ? bus.req_data1 : bus.req_data0;
            sh_amt_r     <= grant_s[1] ? bus.req_amt1  : bus.req_amt0;
            owner_r      <= grant_s[1] ? PORT_PWM : PORT_ALU;
        end
    end

    // Result capture happens only in SHIFT, so a floating shifter is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_data_r <= {DATA_W{1'b0}};
        end else if (state_r == SHIFT) begin
            resp_data_r <= sh_result;
        end
    end

    // Tie preference moves away from the owner once its result is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= 1'b0;
        end else if (handoff_s) begin
            rr_ptr_r <= ~owner_r;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign sh_operand     = sh_operand_r;
    assign sh_amt         = sh_amt_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_shift_port_arbiter.sv
// Directed plus randomized bench for shift_port_arbiter; the bench also plays
// the external shifter.
module tb_shift_port_arbiter;
    import shift_port_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] sh_operand;
    logic [4:0]  sh_amt;
    logic [31:0] sh_result;
    logic        busy;
    logic        inject_x = 1'b0;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int pref      = 0;   // port that wins the next tie

    always #5 clock = ~clock;

    shift_port_arbiter_if #(.DATA_W(32), .AMT_W(5)) bus ();

    shift_port_arbiter #(.DATA_W(32), .AMT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .sh_operand (sh_operand),
        .sh_amt     (sh_amt),
        .sh_result  (sh_result),
        .busy       (busy)
    );

    assign sh_result = inject_x ? 32'hxxxx_xxxx : 32'($signed(sh_operand) >>> sh_amt);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reference arbitration: lone requester wins, tie goes to the preferred port.
    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        else if (v == 2'b10) return 1;
        else return pref;
    endfunction

    // Reference arithmetic shift: repeated one-bit sign-filling steps.
    function automatic logic [31:0] model_sra(input logic [31:0] d, input logic [4:0] a);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) r = {r[31], r[31:1]};
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One full transaction starting in IDLE with requests already driven.
    task automatic serve(input string tag, input int port, input logic [31:0] op,
                         input logic [4:0] amt, input logic [31:0] exp_res,
                         input logic other_ready);
        #1;
        check({tag, ".grant"}, 32'(bus.req_ready), 32'(onehot(port)));
        tick;
        check({tag, ".busy_shift"}, 32'(busy), 32'd1);
        check({tag, ".rv_shift"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".sh_operand"}, sh_operand, op);
        check({tag, ".sh_amt"}, 32'(sh_amt), 32'(amt));
        check({tag, ".rdy_shift"}, 32'(bus.req_ready), 32'd0);
        bus.req_data0 = $urandom;
        bus.req_data1 = $urandom;
        bus.req_amt0  = 5'($urandom);
        bus.req_amt1  = 5'($urandom);
        bus.resp_ready = other_ready ? onehot(1 - port) : 2'b00;
        tick;
        check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'(onehot(port)));
        check({tag, ".resp_data"}, bus.resp_data, exp_res);
        check({tag, ".op_stable"}, sh_operand, op);
        check({tag, ".rdy_resp"}, 32'(bus.req_ready), 32'd0);
        inject_x = 1'b1;
        bus.resp_ready = onehot(port);
        tick;
        inject_x = 1'b0;
        bus.resp_ready = 2'b00;
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".rv_done"}, 32'(bus.resp_valid), 32'd0);
        check({tag, ".data_held"}, bus.resp_data, exp_res);
        pref = 1 - port;
    endtask

    typedef struct { logic [31:0] d; logic [4:0] a; logic [31:0] r; } vec_t;

    initial begin
        vec_t vecs[4];
        logic [1:0]  v;
        logic [31:0] d0, d1, op, hold;
        logic [4:0]  a0, a1, amt;
        int          p;

        vecs[0] = '{32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[1] = '{32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
        vecs[2] = '{32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[3] = '{32'h1234_5678, 5'd0,  32'h1234_5678};

        bus.req_valid = 2'b11;
        bus.req_data0 = 32'd0; bus.req_amt0 = 5'd0;
        bus.req_data1 = 32'd0; bus.req_amt1 = 5'd0;
        bus.resp_ready = 2'b00;

        // Reset state
        tick; tick;
        check("rst.req_ready", 32'(bus.req_ready), 32'd0);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_data", bus.resp_data, 32'd0);
        check("rst.sh_operand", sh_operand, 32'd0);
        check("rst.sh_amt", 32'(sh_amt), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);

        // Lone port-1 requester while port 0 is preferred
        reset = 1'b0;
        bus.req_valid = 2'b10;
        bus.req_data1 = 32'hF000_0000; bus.req_amt1 = 5'd4;
        serve("lone1", 1, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0);

        // Directed port-0 arithmetic
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 2'b01;
            bus.req_data0 = vecs[i].d; bus.req_amt0 = vecs[i].a;
            serve($sformatf("arith%0d", i), 0, vecs[i].d, vecs[i].a, vecs[i].r, 1'b1);
        end

        // resp_ready with no response pending is ignored
        bus.req_valid = 2'b00;
        bus.resp_ready = 2'b11;
        tick;
        check("idle_rr.busy", 32'(busy), 32'd0);
        check("idle_rr.rv", 32'(bus.resp_valid), 32'd0);
        bus.resp_ready = 2'b00;

        // Tie arbitration from reset
        reset = 1'b1; tick; reset = 1'b0; pref = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 2'b11;
            bus.req_data0 = 32'h0000_0100; bus.req_amt0 = 5'd8;
            bus.req_data1 = 32'hFFFF_0000; bus.req_amt1 = 5'd16;
            if (i % 2 == 0) serve($sformatf("tie%0d", i), 0, 32'h0000_0100, 5'd8, 32'h0000_0001, 1'b0);
            else            serve($sformatf("tie%0d", i), 1, 32'hFFFF_0000, 5'd16, 32'hFFFF_FFFF, 1'b0);
        end

        // Back-pressure on port 1 with port 0 waiting
        bus.req_valid = 2'b10;
        bus.req_data1 = 32'h8000_1234; bus.req_amt1 = 5'd12;
        #1;
        check("bp.grant", 32'(bus.req_ready), 32'h2);
        tick;
        bus.req_valid = 2'b11;
        tick;
        hold = bus.resp_data;
        check("bp.data", hold, 32'hFFF8_0001);
        for (int i = 0; i < 10; i++) begin
            bus.resp_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
            tick;
            check("bp.rv", 32'(bus.resp_valid), 32'h2);
            check("bp.hold", bus.resp_data, hold);
            check("bp.busy", 32'(busy), 32'd1);
            check("bp.rdy", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 2'b10;
        tick;
        bus.resp_ready = 2'b00;
        pref = 0;
        check("bp.release", 32'(busy), 32'd0);
        bus.req_data0 = 32'hC000_0000; bus.req_amt0 = 5'd1;
        serve("bp.next0", 0, 32'hC000_0000, 5'd1, 32'hE000_0000, 1'b0);

        // Asynchronous reset during SHIFT
        bus.req_valid = 2'b01;
        bus.req_data0 = 32'h8765_4321; bus.req_amt0 = 5'd3;
        tick;
        #2 reset = 1'b1;
        #1;
        check("rst_sh.busy", 32'(busy), 32'd0);
        check("rst_sh.sh_operand", sh_operand, 32'd0);
        check("rst_sh.sh_amt", 32'(sh_amt), 32'd0);
        check("rst_sh.rdy", 32'(bus.req_ready), 32'd0);
        #1 reset = 1'b0; pref = 0;

        // Asynchronous reset during RESP
        bus.req_valid = 2'b11;
        tick; tick;
        check("rst_rp.pre_rv", 32'(bus.resp_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_rp.rv", 32'(bus.resp_valid), 32'd0);
        check("rst_rp.data", bus.resp_data, 32'd0);
        check("rst_rp.busy", 32'(busy), 32'd0);
        #1 reset = 1'b0; pref = 0;
        bus.req_data0 = 32'h0000_00F0; bus.req_amt0 = 5'd4;
        bus.req_data1 = 32'h8000_0000; bus.req_amt1 = 5'd1;
        serve("rst.tie0", 0, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 24; i++) begin
            v  = 2'($urandom_range(1, 3));
            d0 = $urandom; d1 = $urandom;
            a0 = 5'($urandom); a1 = 5'($urandom);
            bus.req_valid = v;
            bus.req_data0 = d0; bus.req_amt0 = a0;
            bus.req_data1 = d1; bus.req_amt1 = a1;
            p   = model_grant(v);
            op  = (p == 1) ? d1 : d0;
            amt = (p == 1) ? a1 : a0;
            serve($sformatf("rnd%0d", i), p, op, amt, model_sra(op, amt), 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
